// File: rtl/link_ber_monitor.sv
// PRBS BER monitor: sweeps (phase, delay) candidates, locks on the first clean window, counts bits/errors.
// Latency: every output is registered and updates one cycle after the strobe or edge that causes it.
// Backpressure: none; a strobe may be accepted on every cycle.
module link_ber_monitor #(
  parameter int NPHASE   = 4,
  parameter int MAX_DLY  = 16,
  parameter int WIN_LEN  = 511,
  parameter int LOSS_THR = 8,
  parameter int CNT_W    = 32,
  localparam int PH_W    = $clog2(NPHASE),
  localparam int DL_W    = $clog2(MAX_DLY)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_enable,
  input  logic              i_valid,
  input  logic              i_ref_bit,
  input  logic [NPHASE-1:0] i_det,
  input  logic              i_clr,
  output logic              o_lock,
  output logic [PH_W-1:0]   o_phase,
  output logic [DL_W-1:0]   o_delay,
  output logic [CNT_W-1:0]  o_bit_cnt,
  output logic [CNT_W-1:0]  o_err_cnt,
  output logic              o_search_fail
);

  localparam int WC_W = $clog2(WIN_LEN + 1);
  localparam int WE_W = $clog2(LOSS_THR + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SEARCH, ST_LOCK} state_t;
  state_t state, state_nxt;

  logic [MAX_DLY-2:0] hist;
  logic [MAX_DLY-1:0] ref_vec;
  logic [WC_W-1:0]    win_cnt;
  logic [WE_W-1:0]    win_err;
  logic [WE_W-1:0]    win_err_nxt;
  logic               strobe;
  logic               mis;
  logic               win_end;
  logic               go_lock;
  logic               go_loss;
  logic               advance;

  // ref_vec[d] is the reference bit from d strobes ago; index 0 is the live bit.
  assign strobe      = i_valid & i_enable;
  assign ref_vec     = {hist, i_ref_bit};
  assign mis         = i_det[o_phase] ^ ref_vec[o_delay];
  assign win_end     = strobe && (state != ST_IDLE) && (win_cnt == WC_W'(WIN_LEN - 1));
  assign win_err_nxt = (win_err == WE_W'(LOSS_THR)) ? win_err : win_err + WE_W'(mis);

  always_comb begin
    state_nxt = state;
    go_lock   = 1'b0;
    go_loss   = 1'b0;
    advance   = 1'b0;
    if (!i_enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_SEARCH;
        ST_SEARCH: begin
          if (win_end) begin
            if (win_err_nxt == '0) begin
              state_nxt = ST_LOCK;
              go_lock   = 1'b1;
            end else begin
              advance = 1'b1;
            end
          end
        end
        ST_LOCK: begin
          if (win_end && (win_err_nxt >= WE_W'(LOSS_THR))) begin
            state_nxt = ST_SEARCH;
            go_loss   = 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      o_lock <= 1'b0;
    end else begin
      state  <= state_nxt;
      o_lock <= (state_nxt == ST_LOCK);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist <= '0;
    end else if (strobe) begin
      hist <= ref_vec[MAX_DLY-2:0];
    end
  end

  // Candidate sweep: delay is the fast index, phase the slow one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_phase       <= '0;
      o_delay       <= '0;
      o_search_fail <= 1'b0;
    end else if (i_enable && (state == ST_IDLE)) begin
      o_phase <= '0;
      o_delay <= '0;
    end else if (go_loss) begin
      o_phase <= '0;
      o_delay <= '0;
    end else if (advance) begin
      if (o_delay == DL_W'(MAX_DLY - 1)) begin
        o_delay <= '0;
        if (o_phase == PH_W'(NPHASE - 1)) begin
          o_phase       <= '0;
          o_search_fail <= 1'b1;
        end else begin
          o_phase <= o_phase + PH_W'(1);
        end
      end else begin
        o_delay <= o_delay + DL_W'(1);
      end
    end else if (go_lock) begin
      o_search_fail <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_cnt <= '0;
      win_err <= '0;
    end else if (i_enable && (state == ST_IDLE)) begin
      win_cnt <= '0;
      win_err <= '0;
    end else if (strobe && (state != ST_IDLE)) begin
      if (win_end) begin
        win_cnt <= '0;
        win_err <= '0;
      end else begin
        win_cnt <= win_cnt + WC_W'(1);
        win_err <= win_err_nxt;
      end
    end
  end

  // Clear beats a same-cycle increment; lock entry starts the counts from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_bit_cnt <= '0;
      o_err_cnt <= '0;
    end else if (i_clr || go_lock) begin
      o_bit_cnt <= '0;
      o_err_cnt <= '0;
    end else if (strobe && (state == ST_LOCK)) begin
      if (o_bit_cnt != '1) o_bit_cnt <= o_bit_cnt + CNT_W'(1);
      if (mis && (o_err_cnt != '1)) o_err_cnt <= o_err_cnt + CNT_W'(1);
    end
  end

endmodule
